imem_fetch_ctrl: RTL and testbench

Fetch sequencer and load arbiter for the single-cycle CPU's instruction memory. After reset it owns the memory write port and accepts a boot image from a loader over a valid/ready handshake. It then switches to RUN, where it generates the fetch PC every cycle from stall, branch and jump inputs. It detects end-of-program and fault conditions and parks the core in HALT or FAULT until restarted.

---
 rtl/imem_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: boot-image loader arbiter and fetch-PC sequencer for the
// single-cycle core's instruction memory. LOAD owns the memory write port,
// RUN generates the fetch PC, HALT/FAULT park the core until restart.
module imem_fetch_ctrl #(
  parameter int          DEPTH    = 64,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          load_done,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic [31:0]   pc,
  input  logic [31:0]   instruction,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  output logic          fetch_valid,
  output logic          halt,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [31:0]   instr_count,
  input  logic          restart
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [32:0] PC_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  // A fetch address is legal only inside the instruction memory.
  function automatic logic addr_in_range(input logic [32:0] addr);
    return addr < PC_LIMIT;
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [AW:0]   ld_cnt_q, ld_cnt_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic          load_accept;
  logic [AW:0]   ld_cnt_inc;
  logic [32:0]   pc_plus4;

  // Next-state, PC and retire logic; RUN priority is stall > ebreak > branch > sequential.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    ld_cnt_d     = ld_cnt_q;
    fault_code_d = fault_code_q;
    load_accept  = load_valid & (state_q == S_LOAD);
    ld_cnt_inc   = ld_cnt_q + {{AW{1'b0}}, load_accept};
    pc_plus4     = {1'b0, pc_q} + 33'd4;
    case (state_q)
      S_LOAD: begin
        ld_cnt_d = ld_cnt_inc;
        // A word accepted alongside load_done is still written this edge.
        if (load_done || (ld_cnt_inc == CNT_FULL)) begin
          state_d  = S_RUN;
          pc_d     = RESET_PC;
          ld_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (instruction == EBREAK) begin
            state_d = S_HALT;
          end else if (br_taken) begin
            if (br_target[1:0] != 2'b00) begin
              state_d      = S_FAULT;
              fault_code_d = 2'd1;
            end else if (!addr_in_range({1'b0, br_target})) begin
              state_d      = S_FAULT;
              fault_code_d = 2'd2;
            end else begin
              pc_d  = br_target;
              cnt_d = cnt_q + 32'd1;
            end
          end else if (!addr_in_range(pc_plus4)) begin
            state_d      = S_FAULT;
            fault_code_d = 2'd2;
          end else begin
            pc_d  = pc_plus4[31:0];
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: begin
        // HALT and FAULT hold everything until a restart.
        if (restart) begin
          state_d      = S_RUN;
          pc_d         = RESET_PC;
          cnt_d        = '0;
          fault_code_d = 2'd0;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any load or run immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_LOAD;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      ld_cnt_q     <= '0;
      fault_code_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      ld_cnt_q     <= ld_cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign load_ready  = (state_q == S_LOAD);
  assign imem_we     = load_accept;
  assign imem_waddr  = load_addr;
  assign imem_wdata  = load_data;
  assign pc          = pc_q;
  assign fetch_valid = (state_q == S_RUN);
  assign halt        = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign fault_code  = fault_code_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: stimulus pushes expected memory writes
// and expected per-cycle fetch state; a negedge monitor pops and compares.
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          load_done;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   pc;
  logic [31:0]   instruction;
  logic          stall;
  logic          br_taken;
  logic [31:0]   br_target;
  logic          fetch_valid;
  logic          halt;
  logic          fault;
  logic [1:0]    fault_code;
  logic [31:0]   instr_count;
  logic          restart;

  int checks   = 0;
  int errors   = 0;
  int n_writes = 0;
  logic [63:0] wq[$];
  logic [63:0] fq[$];
  logic [31:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .instruction(instruction), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .fetch_valid(fetch_valid), .halt(halt), .fault(fault),
    .fault_code(fault_code), .instr_count(instr_count), .restart(restart)
  );

  // Instruction memory model: written by the DUT write port, read combinationally.
  always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
  assign instruction = mem[pc[AW+1:2]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every RUN cycle must match the head of its queue.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_writes++;
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_waddr, imem_wdata);
      end else begin
        check("write", {{(32-AW){1'b0}}, imem_waddr, imem_wdata}, wq.pop_front());
      end
    end
    if (fetch_valid === 1'b1) begin
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fetch: got pc %0h count %0h expected fetch_valid 0", pc, instr_count);
      end else begin
        check("fetch_pc_count", {pc, instr_count}, fq.pop_front());
      end
    end
  end

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d, input logic done);
    load_valid = 1'b1; load_addr = a; load_data = d; load_done = done;
    wq.push_back({{(32-AW){1'b0}}, a, d});
    @(posedge clk); #1;
    load_valid = 1'b0; load_done = 1'b0;
  endtask

  task automatic run_cycle(input logic s, input logic b, input logic [31:0] t,
                           input logic [31:0] ep, input logic [31:0] ec);
    stall = s; br_taken = b; br_target = t;
    fq.push_back({ep, ec});
    @(posedge clk); #1;
    stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, 64'(load_ready), 64'd1);
    check({tag, "_fetch_valid"}, 64'(fetch_valid), 64'd0);
    check({tag, "_halt_fault"}, {62'd0, halt, fault}, 64'd0);
    check({tag, "_pc"}, 64'(pc), 64'h0);
    check({tag, "_count"}, 64'(instr_count), 64'd0);
    check({tag, "_fault_code"}, 64'(fault_code), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    stall = 1'b0; br_taken = 1'b0; br_target = '0; restart = 1'b0;
    #2;
    check_reset_outputs("reset");
    check("reset_imem_we", 64'(imem_we), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Full 64-word load without load_done; restart held high must be ignored in LOAD.
    restart = 1'b1;
    for (int i = 0; i < DEPTH; i++) load_word(AW'(i), 32'hA500_0000 | 32'(i), 1'b0);
    restart = 1'b0;
    check("auto_run_load_ready", 64'(load_ready), 64'd0);
    check("auto_run_fetch_valid", 64'(fetch_valid), 64'd1);
    // Load handshakes in RUN must not write.
    load_valid = 1'b1; load_addr = 6'd5; load_data = 32'hDEAD_BEEF;
    run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    run_cycle(1'b0, 1'b0, 32'h0, 32'h4, 32'd1);
    run_cycle(1'b0, 1'b0, 32'h0, 32'h8, 32'd2);
    load_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_after_autorun");
    @(posedge clk); #1 rst = 1'b1;

    // 37-word load, word 36 (0x90) is ebreak, then a separate load_done pulse.
    for (int i = 0; i < 37; i++)
      load_word(AW'(i), (i == 36) ? EBREAK : (32'h1000_0000 + 32'(i)), 1'b0);
    load_done = 1'b1;
    @(posedge clk); #1 load_done = 1'b0;
    check("write_count", 64'(n_writes), 64'd101);
    check("first_run_valid", 64'(fetch_valid), 64'd1);
    check("first_run_pc", 64'(pc), 64'h0);

    // Branch at 0x1C to 0x38, two stall cycles, then misaligned target 0x3E.
    for (int k = 0; k < 7; k++) run_cycle(1'b0, 1'b0, 32'h0, 32'(4*k), 32'(k));
    run_cycle(1'b0, 1'b1, 32'h38, 32'h1C, 32'd7);
    run_cycle(1'b1, 1'b0, 32'h0, 32'h38, 32'd8);
    run_cycle(1'b1, 1'b0, 32'h0, 32'h38, 32'd8);
    run_cycle(1'b0, 1'b0, 32'h0, 32'h38, 32'd8);
    run_cycle(1'b0, 1'b1, 32'h3E, 32'h3C, 32'd9);
    check("misalign_fault", {62'd0, halt, fault}, 64'd1);
    check("misalign_code", 64'(fault_code), 64'd1);
    check("misalign_pc", 64'(pc), 64'h3C);
    check("misalign_count", 64'(instr_count), 64'd9);
    br_taken = 1'b1; br_target = 32'h10;
    repeat (2) @(posedge clk);
    #1 br_taken = 1'b0; br_target = 32'h0;
    check("fault_frozen", {pc, instr_count}, {32'h3C, 32'd9});
    pulse_restart();
    check("restart1_state", {61'd0, fetch_valid, halt, fault}, 64'd4);
    check("restart1_pc_count", {pc, instr_count}, 64'd0);
    check("restart1_code", 64'(fault_code), 64'd0);

    // Straight-line run, hop over the ebreak at 0x90, then run off the end at 0xFC.
    for (int k = 0; k < 35; k++) run_cycle(1'b0, 1'b0, 32'h0, 32'(4*k), 32'(k));
    run_cycle(1'b0, 1'b1, 32'h94, 32'h8C, 32'd35);
    for (int j = 0; j <= 26; j++) run_cycle(1'b0, 1'b0, 32'h0, 32'h94 + 32'(4*j), 32'(36+j));
    check("range_fault", {62'd0, halt, fault}, 64'd1);
    check("range_code", 64'(fault_code), 64'd2);
    check("range_pc_count", {pc, instr_count}, {32'hFC, 32'd62});
    pulse_restart();
    check("restart2_pc_count", {pc, instr_count}, 64'd0);

    // ebreak at 0x90 wins over a taken branch.
    for (int k = 0; k < 36; k++) run_cycle(1'b0, 1'b0, 32'h0, 32'(4*k), 32'(k));
    run_cycle(1'b0, 1'b1, 32'h40, 32'h90, 32'd36);
    check("halt_state", {61'd0, fetch_valid, halt, fault}, 64'd2);
    check("halt_code", 64'(fault_code), 64'd0);
    load_valid = 1'b1; load_addr = 6'd3; load_data = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 load_valid = 1'b0;
    check("halt_frozen", {pc, instr_count}, {32'h90, 32'd36});
    pulse_restart();

    // Asynchronous reset in the middle of RUN.
    run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    run_cycle(1'b0, 1'b0, 32'h0, 32'h4, 32'd1);
    run_cycle(1'b0, 1'b0, 32'h0, 32'h8, 32'd2);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1 rst = 1'b1;

    // A word presented with load_done is still written, then RUN starts.
    load_word(6'd0, 32'h0000_0013, 1'b0);
    load_word(6'd1, 32'h0000_0033, 1'b1);
    check("done_with_word_run", 64'(fetch_valid), 64'd1);
    run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    rst = 1'b0;
    #1;
    check("final_reset_ready", 64'(load_ready), 64'd1);
    @(posedge clk); #1;
    check("queues_drained", {32'(wq.size()), 32'(fq.size())}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
